// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default geometry and the wait-counter width.
package mem_if_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        WR   = 2'b10,
        RD   = 2'b11
    } state_e;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Wide enough for the full WAIT_CYCLES range 0..15
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Register-file storage for mem_responder: synchronous write, registered
// read. Optional macro MEM_PARITY_EN adds an even-parity column that is
// checked on every read.
module mem_array
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
`ifdef MEM_PARITY_EN
    ,
    input  logic              flip_i,
    output logic              par_err_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Store the word; a write coinciding with reset is dropped so an aborted
    // access never reaches the array.
    always_ff @(posedge clk_i) begin
        if (rst_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read port; the output holds until the next read or reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef MEM_PARITY_EN
    logic par_q [DEPTH];
    logic par_err_q;

    // Parity column; flip_i deliberately corrupts the stored bit.
    always_ff @(posedge clk_i) begin
        if (rst_i && we_i) begin
            par_q[addr_i] <= (^wdata_i) ^ flip_i;
        end
    end

    // Parity check result, pulses alongside the read data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= re_i && ((^mem_q[addr_i]) != par_q[addr_i]);
        end
    end

    assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/mem_responder.sv
// Storage-side responder for the write/read strobe interface. Accepts one
// access at a time, waits WAIT_CYCLES, then completes with a one-cycle
// wdone or rvalid pulse. Protocol violations pulse err.
// Optional macro MEM_PARITY_EN adds parity storage and the parity_flip input.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wdone,
    output logic              busy,
    output logic              err
`ifdef MEM_PARITY_EN
    ,
    input  logic              parity_flip
`endif
);

    localparam bit               HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               wdone_q, wdone_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               op_wr_q;

    logic               accept;
    logic               mem_we;
    logic               mem_re;
    logic               any_strobe;
    logic               both_strobe;

    assign any_strobe  = write_enb | read_enb;
    assign both_strobe = write_enb & read_enb;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        wdone_d  = 1'b0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        accept   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;

        case (state_q)
            IDLE: begin
                if (both_strobe) begin
                    err_d = 1'b1;
                end else if (any_strobe) begin
                    accept = 1'b1;
                    busy_d = 1'b1;
                    if (HAS_WAIT) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = write_enb ? WR : RD;
                    end
                end
            end
            WAIT: begin
                err_d = any_strobe;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = op_wr_q ? WR : RD;
                end
            end
            WR: begin
                err_d   = any_strobe;
                mem_we  = 1'b1;
                wdone_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            RD: begin
                err_d    = any_strobe;
                mem_re   = 1'b1;
                rvalid_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wdone_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wdone_q  <= wdone_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Capture the access operands when a strobe is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_wr_q <= write_enb;
        end
    end

`ifdef MEM_PARITY_EN
    logic flip_q;
    logic par_err;

    // Capture the parity corruption request together with the write data.
    always_ff @(posedge clk) begin
        if (accept) begin
            flip_q <= parity_flip;
        end
    end
`endif

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (mem_we),
        .re_i      (mem_re),
        .addr_i    (addr_q),
        .wdata_i   (wdata_q),
        .rdata_o   (rdata)
`ifdef MEM_PARITY_EN
        ,
        .flip_i    (flip_q),
        .par_err_o (par_err)
`endif
    );

    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;
    assign busy   = busy_q;
`ifdef MEM_PARITY_EN
    assign err    = err_q | par_err;
`else
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 0, 1, 3) share one
// stimulus stream. A transaction-level model predicts every output after
// every clock edge; literal expectations pin the key scenarios.
module tb_mem_responder;

    localparam int NMAX = 1024;
    localparam int NI   = 3;

    logic       clk;
    logic       rst;
    logic       write_enb;
    logic       read_enb;
    logic [3:0] addr;
    logic [7:0] wdata;
`ifdef MEM_PARITY_EN
    logic       parity_flip;
`endif

    logic [7:0] rd0, rd1, rd3;
    logic [2:0] rvalid_v, wdone_v, busy_v, err_v;

    int checks = 0;
    int errors = 0;
    int nedge  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .rst(rst), .write_enb(write_enb), .read_enb(read_enb),
        .addr(addr), .wdata(wdata), .rdata(rd0), .rvalid(rvalid_v[0]),
        .wdone(wdone_v[0]), .busy(busy_v[0]), .err(err_v[0])
`ifdef MEM_PARITY_EN
        , .parity_flip(parity_flip)
`endif
    );

    mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) u_d1 (
        .clk(clk), .rst(rst), .write_enb(write_enb), .read_enb(read_enb),
        .addr(addr), .wdata(wdata), .rdata(rd1), .rvalid(rvalid_v[1]),
        .wdone(wdone_v[1]), .busy(busy_v[1]), .err(err_v[1])
`ifdef MEM_PARITY_EN
        , .parity_flip(parity_flip)
`endif
    );

    mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) u_d3 (
        .clk(clk), .rst(rst), .write_enb(write_enb), .read_enb(read_enb),
        .addr(addr), .wdata(wdata), .rdata(rd3), .rvalid(rvalid_v[2]),
        .wdone(wdone_v[2]), .busy(busy_v[2]), .err(err_v[2])
`ifdef MEM_PARITY_EN
        , .parity_flip(parity_flip)
`endif
    );

    // ---------------- model state ----------------
    logic       e_wd [NI][NMAX];
    logic       e_rv [NI][NMAX];
    logic       e_er [NI][NMAX];
    logic       e_bz [NI][NMAX];
    logic [7:0] e_rd [NI][NMAX];
    logic [7:0] mm   [NI][16];
    logic       pf   [NI][16];
    logic [7:0] rdv  [NI];
    logic       pend [NI];
    int         pc   [NI];
    logic       pwr  [NI];
    logic [3:0] pa   [NI];
    logic [7:0] pd   [NI];
    logic       pfl  [NI];
    int         free_at [NI];

    function automatic int wv(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    function automatic logic [7:0] initv(input int a);
        return 8'(a * 17) ^ 8'h3C;
    endfunction

    function automatic logic [7:0] rd_of(input int i);
        return (i == 0) ? rd0 : (i == 1) ? rd1 : rd3;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model of one instance at clock edge n, from the protocol rules:
    // an accepted access completes WAIT+1 edges later, busy covers the
    // interval, the responder is free again the edge after completion.
    task automatic step(input int i, input int n);
        int c;
        logic flip;
        flip = 1'b0;
`ifdef MEM_PARITY_EN
        flip = parity_flip;
`endif
        if (!rst) begin
            pend[i]    = 1'b0;
            free_at[i] = n + 1;
            rdv[i]     = 8'h00;
            for (int j = n; j < NMAX; j++) e_bz[i][j] = 1'b0;
        end else begin
            if (pend[i] && pc[i] == n) begin
                pend[i] = 1'b0;
                if (pwr[i]) begin
                    mm[i][pa[i]] = pd[i];
                    pf[i][pa[i]] = pfl[i];
                    e_wd[i][n]   = 1'b1;
                end else begin
                    rdv[i]     = mm[i][pa[i]];
                    e_rv[i][n] = 1'b1;
                    if (pf[i][pa[i]]) e_er[i][n] = 1'b1;
                end
            end
            if (write_enb && read_enb) begin
                e_er[i][n] = 1'b1;
            end else if (write_enb || read_enb) begin
                if (n >= free_at[i]) begin
                    c       = n + wv(i) + 1;
                    pend[i] = 1'b1;
                    pc[i]   = c;
                    pwr[i]  = write_enb;
                    pa[i]   = addr;
                    pd[i]   = wdata;
                    pfl[i]  = flip;
                    for (int k = n; k < c && k < NMAX; k++) e_bz[i][k] = 1'b1;
                    free_at[i] = c + 1;
                end else begin
                    e_er[i][n] = 1'b1;
                end
            end
        end
        e_rd[i][n] = rdv[i];
    endtask

    // Model update on every rising edge
    initial begin
        for (int i = 0; i < NI; i++) begin
            rdv[i] = 8'h00; pend[i] = 1'b0; pc[i] = 0; free_at[i] = 0;
            pwr[i] = 1'b0; pa[i] = 4'h0; pd[i] = 8'h00; pfl[i] = 1'b0;
            for (int a = 0; a < 16; a++) begin mm[i][a] = 8'hxx; pf[i][a] = 1'b0; end
            for (int j = 0; j < NMAX; j++) begin
                e_wd[i][j] = 1'b0; e_rv[i][j] = 1'b0; e_er[i][j] = 1'b0;
                e_bz[i][j] = 1'b0; e_rd[i][j] = 8'h00;
            end
        end
        forever begin
            @(posedge clk);
            if (nedge < NMAX) begin
                for (int i = 0; i < NI; i++) step(i, nedge);
            end
            nedge++;
        end
    end

    // Compare every output of every instance half a cycle after each edge
    initial begin
        forever begin
            @(negedge clk);
            if (nedge > 0 && nedge <= NMAX) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("d%0d_wdone@%0d", i, nedge - 1), {7'b0, wdone_v[i]}, {7'b0, e_wd[i][nedge-1]});
                    chk($sformatf("d%0d_rvalid@%0d", i, nedge - 1), {7'b0, rvalid_v[i]}, {7'b0, e_rv[i][nedge-1]});
                    chk($sformatf("d%0d_busy@%0d", i, nedge - 1), {7'b0, busy_v[i]}, {7'b0, e_bz[i][nedge-1]});
                    chk($sformatf("d%0d_err@%0d", i, nedge - 1), {7'b0, err_v[i]}, {7'b0, e_er[i][nedge-1]});
                    chk($sformatf("d%0d_rdata@%0d", i, nedge - 1), rd_of(i), e_rd[i][nedge-1]);
                end
            end
        end
    end

    // One-cycle strobe, returns just after the sampling edge
    task automatic strobe(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
        write_enb = w; read_enb = r; addr = a; wdata = d;
        @(posedge clk); #1;
        write_enb = 1'b0; read_enb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Directed stimulus with literal expectations
    initial begin
        rst = 1'b0; write_enb = 1'b0; read_enb = 1'b0; addr = 4'h0; wdata = 8'h00;
`ifdef MEM_PARITY_EN
        parity_flip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_rdata", rd1, 8'h00);
        chk("rst_rvalid", {7'b0, rvalid_v[1]}, 8'h00);
        chk("rst_wdone", {7'b0, wdone_v[1]}, 8'h00);
        chk("rst_busy", {5'b0, busy_v}, 8'h00);
        chk("rst_err", {5'b0, err_v}, 8'h00);
        @(posedge clk); #1;

        // Fill every address with a known pattern
        for (int a = 0; a < 16; a++) begin
            strobe(1'b1, 1'b0, 4'(a), initv(a));
            idle(4);
        end

        // Write then read, completion timing per wait setting
        strobe(1'b1, 1'b0, 4'h3, 8'hA5);
        @(posedge clk); @(negedge clk);
        chk("wr_wdone_early_d1", {7'b0, wdone_v[1]}, 8'h00);
        chk("wr_wdone_d0", {7'b0, wdone_v[0]}, 8'h01);
        @(posedge clk); @(negedge clk);
        chk("wr_wdone_d1", {7'b0, wdone_v[1]}, 8'h01);
        chk("wr_wdone_notyet_d3", {7'b0, wdone_v[2]}, 8'h00);
        @(posedge clk); #1;
        idle(2);
        strobe(1'b0, 1'b1, 4'h3, 8'h00);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rd_rvalid_d1", {7'b0, rvalid_v[1]}, 8'h01);
        chk("rd_rdata_d1", rd1, 8'hA5);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rd_rvalid_d3", {7'b0, rvalid_v[2]}, 8'h01);
        chk("rd_rdata_d3", rd3, 8'hA5);
        @(posedge clk); #1;
        idle(2);

        // Both strobes at once: error only, no access
        strobe(1'b1, 1'b1, 4'h3, 8'h5A);
        @(negedge clk);
        chk("both_err", {5'b0, err_v}, 8'h07);
        chk("both_busy", {5'b0, busy_v}, 8'h00);
        @(posedge clk); #1;
        idle(4);
        strobe(1'b0, 1'b1, 4'h3, 8'h00);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("both_old_rdata_d1", rd1, 8'hA5);
        @(posedge clk); #1;
        idle(3);

        // Strobe while busy
        strobe(1'b1, 1'b0, 4'h1, 8'h11);
        idle(1);
        strobe(1'b0, 1'b1, 4'h5, 8'h00);
        @(negedge clk);
        chk("busy_err_d3", {7'b0, err_v[2]}, 8'h01);
        chk("busy_err_d1", {7'b0, err_v[1]}, 8'h01);
        chk("busy_still_d3", {7'b0, busy_v[2]}, 8'h01);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("busy_wdone_d3", {7'b0, wdone_v[2]}, 8'h01);
        @(posedge clk); #1;
        idle(1);
        strobe(1'b0, 1'b1, 4'h1, 8'h00);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy_rvalid_d3", {7'b0, rvalid_v[2]}, 8'h01);
        chk("busy_rdata_d3", rd3, 8'h11);
        @(posedge clk); #1;
        idle(2);

        // Reset during an access aborts the write
        strobe(1'b1, 1'b0, 4'h2, 8'h77);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wdone", {5'b0, wdone_v}, 8'h00);
        chk("abort_busy", {5'b0, busy_v}, 8'h00);
        idle(4);
        strobe(1'b0, 1'b1, 4'h2, 8'h00);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("abort_rdata_d1", rd1, initv(2));
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("abort_rdata_d3", rd3, initv(2));
        @(posedge clk); #1;
        idle(3);

        // Back-to-back: strobe during the wdone cycle is accepted
        strobe(1'b1, 1'b0, 4'h6, 8'hC3);
        idle(2);
        @(negedge clk);
        chk("b2b_wdone_d1", {7'b0, wdone_v[1]}, 8'h01);
        strobe(1'b0, 1'b1, 4'h6, 8'h00);
        @(negedge clk);
        chk("b2b_no_err_d1", {7'b0, err_v[1]}, 8'h00);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("b2b_rvalid_d1", {7'b0, rvalid_v[1]}, 8'h01);
        chk("b2b_rdata_d1", rd1, 8'hC3);
        @(posedge clk); #1;
        idle(4);

`ifdef MEM_PARITY_EN
        // Corrupted parity is reported with the read data
        parity_flip = 1'b1;
        strobe(1'b1, 1'b0, 4'h9, 8'h0F);
        parity_flip = 1'b0;
        idle(4);
        strobe(1'b0, 1'b1, 4'h9, 8'h00);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("par_rvalid_d1", {7'b0, rvalid_v[1]}, 8'h01);
        chk("par_rdata_d1", rd1, 8'h0F);
        chk("par_err_d1", {7'b0, err_v[1]}, 8'h01);
        @(posedge clk); #1;
        idle(4);
`endif

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Storage-side responder for the write/read strobe interface driven by the memory controller FSM.
- Holds a DATA_W x 2**ADDR_W register-file memory and executes each single-cycle write_enb or read_enb strobe after a programmable access latency.
- Returns a one-cycle completion pulse: wdone for writes, rvalid with rdata for reads.
- Flags protocol violations on err.

Parameters:
- ADDR_W, 4, address width; memory depth is 2**ADDR_W words.
- DATA_W, 8, data word width.
- WAIT_CYCLES, 1, extra wait cycles per access; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- write_enb  input  1  write strobe from controller.
- read_enb  input  1  read strobe from controller.
- addr  input  ADDR_W  access address, sampled with the strobe.
- wdata  input  DATA_W  write data, sampled with write_enb.
- rdata  output  DATA_W  read data, valid while rvalid is 1.
- rvalid  output  1  read completion pulse.
- wdone  output  1  write completion pulse.
- busy  output  1  access in progress; new strobes are not accepted.
- err  output  1  one-cycle protocol-error pulse.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-low. rst is sampled only on the rising edge of clk.
- Reset (rst=0 at a clk edge):
  - state=IDLE, wait counter=0.
  - rdata=0, rvalid=0, wdone=0, busy=0, err=0.
  - Memory contents are not cleared.
  - Reset mid-access aborts the access: a pending write is discarded and no completion pulse is produced.
- All outputs are registered.
- FSM states: IDLE, WAIT, WR, RD.
- IDLE:
  - Exactly one strobe high → latch addr (plus wdata for a write) and set busy=1.
  - If WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0: go directly to WR or RD.
  - Both strobes high → err=1 for one cycle, no access, stay in IDLE.
- WAIT: decrement the counter; at 1, go to WR or RD according to the latched operation.
- WR: mem[latched addr] <= latched wdata; wdone=1, busy=0; go to IDLE.
- RD: rdata <= mem[latched addr]; rvalid=1, busy=0; go to IDLE.
- Latency: the completion pulse is high exactly one cycle, starting WAIT_CYCLES+1 edges after the edge that sampled the strobe.
- Back-to-back: a strobe arriving in the cycle wdone/rvalid is high is accepted (the FSM is already in IDLE).
- Strobe while busy=1: ignored, err=1 for one cycle, and the current access completes unaffected.
- rdata holds its last value after rvalid drops; it changes only on a read completion or reset.
- Address wrap: none needed, since addr spans the full depth exactly.
- Read-after-write to the same address returns the new data.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from wdata at write.
  - On read, parity is recomputed; a mismatch sets err=1 in the same cycle as rvalid.
  - rdata is still returned.
  - An extra debug input (parity_flip, 1 bit) inverts the stored parity bit on writes so the error path can be exercised.
- Undefined: no parity storage, no parity_flip port; err comes only from protocol violations.

Decomposition:
- Shared package mem_if_pkg holds:
  - FSM state encoding constants IDLE=2'b00, WAIT=2'b01, WR=2'b10, RD=2'b11.
  - Default ADDR_W/DATA_W constants.
  - WAIT_CYCLES counter width (4).
- Sub-module mem_array:
  - Synchronous-write, registered-read storage array (plus the parity column when MEM_PARITY_EN is defined).
  - Instantiated once by mem_responder, which keeps the FSM and wait counter.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → rdata=0, rvalid=0, wdone=0, busy=0, err=0.
- Write then read, WAIT_CYCLES=1:
  - write_enb at addr=4'h3, wdata=8'hA5 → wdone high exactly 2 edges later.
  - read_enb at addr=4'h3 → rvalid high 2 edges later with rdata=8'hA5.
- Simultaneous strobes: write_enb=1 and read_enb=1 → err pulses 1 cycle, busy stays 0, and a following read of the target address returns its old data.
- Strobe while busy, WAIT_CYCLES=3: write addr=1 data=8'h11, then read_enb two cycles later → err pulse; wdone arrives on schedule; a read of addr 1 returns 8'h11.
- Reset mid-access: write addr=2 data=8'h77, assert rst=0 during WAIT → no wdone; after release, a read of addr 2 returns the pre-write value.
- MEM_PARITY_EN: write 8'h0F with parity_flip=1, then read → rvalid=1, rdata=8'h0F, err=1 in the same cycle.
